// File: rtl/fetch_queue.sv
// Fetch front end: issues in-order imem requests under a credit limit, buffers
// responses in a small FIFO and feeds the decode pipeline register.
module fetch_queue #(
    parameter int              WORD      = 32,
    parameter int              DEPTH     = 4,
    parameter int              MAX_OUTST = 2,
    parameter logic [WORD-1:0] RESET_PC  = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [WORD-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [WORD-1:0] imem_rdata,
    input  logic            stallD,
    input  logic            redirectD,
    input  logic [WORD-1:0] pcnD,
    output logic [WORD-1:0] pcD,
    output logic [WORD-1:0] instrD,
    output logic            validD
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam int OUT_W = $clog2(MAX_OUTST + 1);

    logic [WORD-1:0]  pcFReg, pcFNext;
    logic [WORD-1:0]  pcRReg, pcRNext;
    logic [OUT_W-1:0] outstReg, outstNext;
    logic [OUT_W-1:0] discardReg, discardNext;
    logic [OCC_W-1:0] occReg, occNext;
    logic [PTR_W-1:0] wrPtrReg, wrPtrNext;
    logic [PTR_W-1:0] rdPtrReg, rdPtrNext;
    logic [WORD-1:0]  pcDReg, instrDReg;
    logic             validDReg;

    logic [WORD-1:0]  fifoPc    [DEPTH];
    logic [WORD-1:0]  fifoInstr [DEPTH];

    logic accept;
    logic pushEn;
    logic popEn;

    // Issue needs both an imem slot and a guaranteed FIFO slot for the answer.
    assign imem_req  = !reset && !redirectD
                       && (int'(outstReg) < MAX_OUTST)
                       && ((int'(occReg) + int'(outstReg)) < DEPTH);
    assign imem_addr = pcFReg;

    assign accept = imem_req && imem_gnt;
    assign pushEn = imem_rvalid && !redirectD && (discardReg == '0);
    assign popEn  = !redirectD && !stallD && (occReg != '0);

    always_comb begin
        pcFNext     = pcFReg;
        pcRNext     = pcRReg;
        outstNext   = outstReg;
        discardNext = discardReg;
        occNext     = occReg;
        wrPtrNext   = wrPtrReg;
        rdPtrNext   = rdPtrReg;

        case ({accept, imem_rvalid})
            2'b10:   outstNext = outstReg + OUT_W'(1);
            2'b01:   outstNext = outstReg - OUT_W'(1);
            default: outstNext = outstReg;
        endcase

        if (redirectD) begin
            pcFNext   = pcnD;
            pcRNext   = pcnD;
            occNext   = '0;
            wrPtrNext = '0;
            rdPtrNext = '0;
            // Every response still in flight now belongs to the abandoned path;
            // pending discards are already a subset of those.
            discardNext = outstReg - (imem_rvalid ? OUT_W'(1) : OUT_W'(0));
        end else begin
            if (accept) begin
                pcFNext = pcFReg + WORD'(4);
            end
            if (imem_rvalid && (discardReg != '0)) begin
                discardNext = discardReg - OUT_W'(1);
            end
            if (pushEn) begin
                pcRNext   = pcRReg + WORD'(4);
                wrPtrNext = wrPtrReg + PTR_W'(1);
            end
            if (popEn) begin
                rdPtrNext = rdPtrReg + PTR_W'(1);
            end
            case ({pushEn, popEn})
                2'b10:   occNext = occReg + OCC_W'(1);
                2'b01:   occNext = occReg - OCC_W'(1);
                default: occNext = occReg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pcFReg     <= RESET_PC;
            pcRReg     <= RESET_PC;
            outstReg   <= '0;
            discardReg <= '0;
            occReg     <= '0;
            wrPtrReg   <= '0;
            rdPtrReg   <= '0;
            pcDReg     <= '0;
            instrDReg  <= '0;
            validDReg  <= 1'b0;
        end else begin
            pcFReg     <= pcFNext;
            pcRReg     <= pcRNext;
            outstReg   <= outstNext;
            discardReg <= discardNext;
            occReg     <= occNext;
            wrPtrReg   <= wrPtrNext;
            rdPtrReg   <= rdPtrNext;
            if (redirectD) begin
                validDReg <= 1'b0;
            end else if (!stallD) begin
                validDReg <= popEn;
                if (popEn) begin
                    pcDReg    <= fifoPc[rdPtrReg];
                    instrDReg <= fifoInstr[rdPtrReg];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (pushEn) begin
            fifoPc[wrPtrReg]    <= pcRReg;
            fifoInstr[wrPtrReg] <= imem_rdata;
        end
    end

    assign pcD    = pcDReg;
    assign instrD = instrDReg;
    assign validD = validDReg;

    noOverflow: assert property (@(posedge clk) disable iff (reset)
        !(pushEn && !popEn && (occReg == OCC_W'(DEPTH))));

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed vector table followed by random traffic
// against a queue-based model of requests in flight and buffered fetches.
module tb_fetch_queue;
    localparam int          DEPTH     = 4;
    localparam int          MAX_OUTST = 2;
    localparam logic [31:0] RST_PC    = 32'h0;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        stallD;
    logic        redirectD;
    logic [31:0] pcnD;
    logic [31:0] pcD;
    logic [31:0] instrD;
    logic        validD;

    fetch_queue #(
        .WORD(32), .DEPTH(DEPTH), .MAX_OUTST(MAX_OUTST), .RESET_PC(RST_PC)
    ) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .stallD(stallD), .redirectD(redirectD), .pcnD(pcnD),
        .pcD(pcD), .instrD(instrD), .validD(validD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        bit          keep;
        int          ready;
    } req_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    typedef struct {
        bit          rst;
        bit          stall;
        bit          redir;
        logic [31:0] pcn;
        bit          gnt;
        bit          rv;
        bit          expReq;
        logic [31:0] expAddr;
        bit          expValid;
        bit          chkPc;
        logic [31:0] expPc;
    } vec_t;

    req_t        infl[$];
    ent_t        fifoQ[$];
    vec_t        vecs[$];
    logic [31:0] mPcF, mPcD, mInstrD;
    bit          mValidD;
    int          cycle;
    int          nChecks;
    int          nFails;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A3C_9E71;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cycle, act, exp);
        end
    endtask

    // One clock: drive, check combinational request side, advance the model,
    // then check the decode register after the edge.
    task automatic step(input bit rst, input bit stall, input bit redir,
                        input logic [31:0] pcn, input bit gnt, input bit rvWant,
                        output bit sReq, output logic [31:0] sAddr);
        bit          rv;
        bit          expReq;
        bit          accept;
        bit          kept;
        ent_t        e;
        @(negedge clk);
        rv = !rst && rvWant && (infl.size() > 0) && (infl[0].ready <= cycle);
        reset       = rst;
        stallD      = stall;
        redirectD   = redir;
        pcnD        = pcn;
        imem_gnt    = gnt;
        imem_rvalid = rv;
        imem_rdata  = rv ? memWord(infl[0].addr) : $urandom();
        #1;
        sReq  = imem_req;
        sAddr = imem_addr;
        expReq = !rst && !redir && (infl.size() < MAX_OUTST)
                 && (fifoQ.size() + infl.size() < DEPTH);
        check("imem_req", {31'b0, imem_req}, {31'b0, expReq});
        check("imem_addr", imem_addr, mPcF);
        accept = expReq && gnt;

        if (rst) begin
            infl.delete();
            fifoQ.delete();
            mPcF    = RST_PC;
            mPcD    = '0;
            mInstrD = '0;
            mValidD = 1'b0;
        end else begin
            kept = 1'b0;
            e.pc = '0;
            e.instr = '0;
            if (rv) begin
                req_t r;
                r = infl.pop_front();
                kept = r.keep && !redir;
                e.pc = r.addr;
                e.instr = memWord(r.addr);
            end
            if (redir) begin
                foreach (infl[i]) infl[i].keep = 1'b0;
                fifoQ.delete();
                mValidD = 1'b0;
                mPcF = pcn;
            end else begin
                if (!stall) begin
                    if (fifoQ.size() > 0) begin
                        ent_t h;
                        h = fifoQ.pop_front();
                        mPcD = h.pc;
                        mInstrD = h.instr;
                        mValidD = 1'b1;
                    end else begin
                        mValidD = 1'b0;
                    end
                end
                if (kept) fifoQ.push_back(e);
                if (accept) begin
                    req_t n;
                    n.addr = mPcF;
                    n.keep = 1'b1;
                    n.ready = cycle + 1;
                    infl.push_back(n);
                    mPcF = mPcF + 32'd4;
                end
            end
        end

        @(posedge clk);
        #1;
        cycle++;
        check("validD", {31'b0, validD}, {31'b0, mValidD});
        check("pcD", pcD, mPcD);
        check("instrD", instrD, mInstrD);
    endtask

    task automatic addVec(input bit rst, input bit stall, input bit redir,
                          input logic [31:0] pcn, input bit gnt, input bit rv,
                          input bit expReq, input logic [31:0] expAddr,
                          input bit expValid, input bit chkPc, input logic [31:0] expPc);
        vec_t v;
        v.rst = rst; v.stall = stall; v.redir = redir; v.pcn = pcn;
        v.gnt = gnt; v.rv = rv; v.expReq = expReq; v.expAddr = expAddr;
        v.expValid = expValid; v.chkPc = chkPc; v.expPc = expPc;
        vecs.push_back(v);
    endtask

    initial begin
        bit          sReq;
        logic [31:0] sAddr;
        logic [31:0] expInstr;
        reset = 1'b1; stallD = 1'b0; redirectD = 1'b0; pcnD = '0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        mPcF = RST_PC; mPcD = '0; mInstrD = '0; mValidD = 1'b0;
        cycle = 0; nChecks = 0; nFails = 0;

        // rst stall redir pcn gnt rv | req addr valid chkPc pc
        addVec(1,0,0,32'h0,  1,0, 0,32'h0,   0,1,32'h0);
        // streaming start: first valid pc 0 in the third cycle
        addVec(0,0,0,32'h0,  1,1, 1,32'h0,   0,0,32'h0);
        addVec(0,0,0,32'h0,  1,1, 1,32'h4,   0,0,32'h0);
        addVec(0,0,0,32'h0,  1,1, 1,32'h8,   1,1,32'h0);
        addVec(0,0,0,32'h0,  1,1, 1,32'hC,   1,1,32'h4);
        addVec(0,0,0,32'h0,  1,1, 1,32'h10,  1,1,32'h8);
        // grant withheld three cycles: address held at 0x14
        addVec(0,0,0,32'h0,  0,1, 1,32'h14,  1,1,32'hC);
        addVec(0,0,0,32'h0,  0,1, 1,32'h14,  1,1,32'h10);
        addVec(0,0,0,32'h0,  0,1, 1,32'h14,  0,1,32'h10);
        addVec(0,0,0,32'h0,  1,1, 1,32'h14,  0,1,32'h10);
        addVec(0,0,0,32'h0,  1,1, 1,32'h18,  0,1,32'h10);
        addVec(0,0,0,32'h0,  1,1, 1,32'h1C,  1,1,32'h14);
        addVec(0,0,0,32'h0,  1,1, 1,32'h20,  1,1,32'h18);
        // build outst = 2 under stall, then redirect with stall and rvalid
        addVec(0,1,0,32'h0,  1,0, 1,32'h24,  1,1,32'h18);
        addVec(0,1,0,32'h0,  1,0, 0,32'h28,  1,1,32'h18);
        addVec(0,1,1,32'h100,1,1, 0,32'h28,  0,0,32'h0);
        addVec(0,0,0,32'h0,  1,1, 1,32'h100, 0,0,32'h0);
        addVec(0,0,0,32'h0,  1,1, 1,32'h104, 0,0,32'h0);
        addVec(0,0,0,32'h0,  1,1, 1,32'h108, 1,1,32'h100);
        addVec(0,0,0,32'h0,  1,1, 1,32'h10C, 1,1,32'h104);
        // eight-cycle stall: FIFO fills, issue closes at occ + outst = 4
        addVec(0,1,0,32'h0,  1,1, 1,32'h110, 1,1,32'h104);
        addVec(0,1,0,32'h0,  1,1, 1,32'h114, 1,1,32'h104);
        for (int i = 0; i < 6; i++)
            addVec(0,1,0,32'h0, 1,1, 0,32'h118, 1,1,32'h104);
        addVec(0,0,0,32'h0,  1,1, 0,32'h118, 1,1,32'h108);
        addVec(0,0,0,32'h0,  1,1, 1,32'h118, 1,1,32'h10C);
        addVec(0,0,0,32'h0,  1,1, 1,32'h11C, 1,1,32'h110);
        addVec(0,0,0,32'h0,  1,1, 1,32'h120, 1,1,32'h114);
        // reset with work in flight, then restart at the reset PC
        addVec(0,1,0,32'h0,  1,0, 1,32'h124, 1,1,32'h114);
        addVec(1,0,0,32'h0,  1,1, 0,32'h128, 0,1,32'h0);
        addVec(0,0,0,32'h0,  1,1, 1,32'h0,   0,0,32'h0);
        addVec(0,0,0,32'h0,  1,1, 1,32'h4,   0,0,32'h0);
        addVec(0,0,0,32'h0,  1,1, 1,32'h8,   1,1,32'h0);

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].stall, vecs[i].redir, vecs[i].pcn,
                 vecs[i].gnt, vecs[i].rv, sReq, sAddr);
            check("vec_req", {31'b0, sReq}, {31'b0, vecs[i].expReq});
            check("vec_addr", sAddr, vecs[i].expAddr);
            check("vec_valid", {31'b0, validD}, {31'b0, vecs[i].expValid});
            if (vecs[i].chkPc) begin
                expInstr = vecs[i].rst ? 32'h0 : memWord(vecs[i].expPc);
                check("vec_pc", pcD, vecs[i].expPc);
                check("vec_instr", instrD, expInstr);
            end
            $display("vec %0d: req=%0b addr=%h validD=%0b pcD=%h instrD=%h",
                     i, sReq, sAddr, validD, pcD, instrD);
        end

        // random traffic; redirects only while no stale responses are pending
        for (int c = 0; c < 3000; c++) begin
            bit          rst, stall, redir, gnt, rvw, clean;
            logic [31:0] pcn;
            clean = 1'b1;
            foreach (infl[i]) if (!infl[i].keep) clean = 1'b0;
            rst   = ($urandom_range(0, 199) == 0);
            stall = ($urandom_range(0, 9) < 3);
            redir = clean && ($urandom_range(0, 19) == 0);
            gnt   = ($urandom_range(0, 9) < 6);
            rvw   = ($urandom_range(0, 9) < 6);
            pcn   = $urandom();
            if ($urandom_range(0, 3) != 0) pcn = pcn & 32'h0000_FFFC;
            step(rst, stall, redir, pcn, gnt, rvw, sReq, sAddr);
            if ((c % 100) == 0)
                $display("rand %0d: req=%0b addr=%h validD=%0b pcD=%h",
                         c, sReq, sAddr, validD, pcD);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
